// File: rtl/clk_div_pkg.sv
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared widths and reset constants for the programmable divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_div_pkg;

    localparam int CLK_DIV_W = 28;

    // 2^26: roughly 0.75 Hz output from a 100 MHz system clock.
    localparam logic [CLK_DIV_W-1:0] CLK_DIV_RESET_HALF = 28'h4000000;

    localparam int CLK_DIV_TICK_W = 16;

endpackage

`default_nettype wire

// File: rtl/clk_div_reload.sv
// ============================================================================
// Module      : clk_div_reload
// Description : Pending half-period register and glitch-free apply decision.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_reload
    import clk_div_pkg::*;
#(
    parameter int                WIDTH      = CLK_DIV_W,
    parameter logic [WIDTH-1:0]  RESET_HALF = WIDTH'(CLK_DIV_RESET_HALF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_half_in,
    input  logic             i_tc,
    output logic [WIDTH-1:0] o_half,
    output logic             o_pend,
    output logic             o_apply
);

    logic [WIDTH-1:0] r_half;
    logic [WIDTH-1:0] r_pend_val;
    logic             r_pend;
    logic             w_apply;

    // Running: swap only at terminal count so no clkOut phase is cut short.
    // Halted: nothing to cut short, so swap on the next edge.
    assign w_apply = r_pend & (~i_en | i_tc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_half     <= RESET_HALF;
            r_pend_val <= '0;
            r_pend     <= 1'b0;
        end else begin
            if (w_apply) begin
                r_half <= r_pend_val;
            end
            // A load coinciding with an apply becomes the next pending value.
            if (i_load) begin
                r_pend_val <= i_half_in;
                r_pend     <= 1'b1;
            end else if (w_apply) begin
                r_pend     <= 1'b0;
            end
        end
    end

    assign o_half  = r_half;
    assign o_pend  = r_pend;
    assign o_apply = w_apply;

endmodule

`default_nettype wire

// File: rtl/clk_div_prog.sv
// ============================================================================
// Module      : clk_div_prog
// Description : Run-time programmable 50% clock divider with tick strobe.
//               Optional tick counter output enabled by CLK_DIV_TICK_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int                WIDTH      = CLK_DIV_W,
    parameter logic [WIDTH-1:0]  RESET_HALF = WIDTH'(CLK_DIV_RESET_HALF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] half_in,
    output logic             clkOut,
    output logic             tick,
    output logic             pend
`ifdef CLK_DIV_TICK_CNT_EN
    ,
    output logic [CLK_DIV_TICK_W-1:0] tick_cnt
`endif
);

    logic [WIDTH-1:0] r_cnt;
    logic             r_clk_out;
    logic             r_tick;
    logic [WIDTH-1:0] w_half;
    logic             w_tc;
    logic             w_apply;

    // Equality suffices: half only changes while cnt is being cleared.
    assign w_tc = (r_cnt == w_half);

    clk_div_reload #(
        .WIDTH      (WIDTH),
        .RESET_HALF (RESET_HALF)
    ) u_reload (
        .clk        (clk),
        .rst        (rst),
        .i_en       (en),
        .i_load     (load),
        .i_half_in  (half_in),
        .i_tc       (w_tc),
        .o_half     (w_half),
        .o_pend     (pend),
        .o_apply    (w_apply)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else if (en) begin
            if (w_tc) begin
                r_cnt     <= '0;
                r_clk_out <= ~r_clk_out;
                r_tick    <= 1'b1;
            end else begin
                r_cnt     <= r_cnt + 1'b1;
                r_tick    <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
            if (w_apply) begin
                r_cnt <= '0;
            end
        end
    end

    assign clkOut = r_clk_out;
    assign tick   = r_tick;

`ifdef CLK_DIV_TICK_CNT_EN
    logic [CLK_DIV_TICK_W-1:0] r_tick_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_apply) begin
            r_tick_cnt <= '0;
        end else if (en && w_tc) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign tick_cnt = r_tick_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_clk_div_prog.sv
// ============================================================================
// Module      : tb_clk_div_prog
// Description : Scoreboard bench for clk_div_prog (WIDTH=8, RESET_HALF=3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_div_prog;

    localparam int C_W = 8;

    typedef struct {
        int   cyc;
        logic lvl;
    } exp_t;

    logic           clk;
    logic           rst;
    logic           en;
    logic           load;
    logic [C_W-1:0] half_in;
    logic           clkOut;
    logic           tick;
    logic           pend;
`ifdef CLK_DIV_TICK_CNT_EN
    logic [15:0]    tick_cnt;
`endif

    int   cyc;
    int   n_tests;
    int   n_fail;
    logic mon_on;
    exp_t sb[$];

    clk_div_prog #(
        .WIDTH      (C_W),
        .RESET_HALF (8'd3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .half_in (half_in),
        .clkOut  (clkOut),
        .tick    (tick),
        .pend    (pend)
`ifdef CLK_DIV_TICK_CNT_EN
        ,
        .tick_cnt(tick_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge number since reset release: edge k leaves cyc == k.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Every observed tick must match the next scheduled toggle.
    always @(negedge clk) begin
        if (mon_on && tick === 1'b1) begin
            exp_t e;
            if (sb.size() > 0) e = sb.pop_front();
            else               e = '{cyc: -1, lvl: 1'bx};
            check("tick_cyc", cyc, e.cyc);
            check("tick_lvl", {31'd0, clkOut}, {31'd0, e.lvl});
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        mon_on  = 1'b0;
        en      = 1'b1;
        load    = 1'b0;
        half_in = '0;
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        check("rst_clkOut", {31'd0, clkOut}, 0);
        check("rst_tick",   {31'd0, tick},   0);
        check("rst_pend",   {31'd0, pend},   0);
        mon_on = 1'b1;
    endtask

    task automatic expect_tick(input int c, input logic l);
        sb.push_back('{cyc: c, lvl: l});
    endtask

    task automatic finish_scn(input int last);
        wait_cyc(last);
        @(negedge clk);
        #1 mon_on = 1'b0;
        check("sb_empty", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        mon_on  = 1'b0;
        rst     = 1'b1;
        en      = 1'b0;
        load    = 1'b0;
        half_in = '0;

        // Reset value: period 8, toggles at 4, 8, 12.
        do_reset();
        expect_tick(4, 1'b1);
        expect_tick(8, 1'b0);
        expect_tick(12, 1'b1);
        finish_scn(12);
`ifdef CLK_DIV_TICK_CNT_EN
        check("tick_cnt_run", {16'd0, tick_cnt}, 3);
`endif

        // Mid-period load of 1 at edge 2: applied at the edge-4 toggle.
        do_reset();
        expect_tick(4, 1'b1);
        expect_tick(6, 1'b0);
        expect_tick(8, 1'b1);
        expect_tick(10, 1'b0);
        wait_cyc(1);
        load = 1'b1; half_in = 8'd1;
        wait_cyc(2);
        load = 1'b0;
        wait_cyc(3);
        check("mid_pend_hi", {31'd0, pend}, 1);
        wait_cyc(4);
        check("mid_pend_lo", {31'd0, pend}, 0);
        finish_scn(10);

        // Load of 0 on the edge-4 terminal count: pending until the edge-8 toggle.
        do_reset();
        expect_tick(4, 1'b1);
        expect_tick(8, 1'b0);
        expect_tick(9, 1'b1);
        expect_tick(10, 1'b0);
        expect_tick(11, 1'b1);
        expect_tick(12, 1'b0);
        wait_cyc(3);
        load = 1'b1; half_in = 8'd0;
        wait_cyc(4);
        load = 1'b0;
        check("tc_load_pend", {31'd0, pend}, 1);
        wait_cyc(8);
        check("tc_load_applied", {31'd0, pend}, 0);
        finish_scn(12);

        // Enable hold from edge 3 through 7: count frozen at 2.
        do_reset();
        expect_tick(9, 1'b1);
        expect_tick(13, 1'b0);
        wait_cyc(2);
        en = 1'b0;
        wait_cyc(5);
        check("hold_cnt",    {24'd0, dut.r_cnt}, 2);
        check("hold_clkOut", {31'd0, clkOut}, 0);
        check("hold_tick",   {31'd0, tick}, 0);
        wait_cyc(7);
        en = 1'b1;
        finish_scn(13);

        // Load 5 while halted: applied on the next edge, then 6-cycle half period.
        do_reset();
        expect_tick(12, 1'b1);
        expect_tick(18, 1'b0);
        expect_tick(24, 1'b1);
        wait_cyc(2);
        en = 1'b0;
        wait_cyc(3);
        load = 1'b1; half_in = 8'd5;
        wait_cyc(4);
        load = 1'b0;
        check("dis_pend_hi", {31'd0, pend}, 1);
        wait_cyc(5);
        check("dis_pend_lo", {31'd0, pend}, 0);
        check("dis_cnt",     {24'd0, dut.r_cnt}, 0);
        check("dis_clkOut",  {31'd0, clkOut}, 0);
        wait_cyc(6);
        en = 1'b1;
        finish_scn(24);

        // Asynchronous reset between edges at cnt=2, clkOut=1, pend=1.
        do_reset();
        expect_tick(4, 1'b1);
        wait_cyc(4);
        load = 1'b1; half_in = 8'd2;
        wait_cyc(5);
        load = 1'b0;
        wait_cyc(6);
        mon_on = 1'b0;
        check("sb_empty", sb.size(), 0);
        check("pre_cnt",    {24'd0, dut.r_cnt}, 2);
        check("pre_clkOut", {31'd0, clkOut}, 1);
        check("pre_pend",   {31'd0, pend}, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_clkOut", {31'd0, clkOut}, 0);
        check("arst_tick",   {31'd0, tick}, 0);
        check("arst_pend",   {31'd0, pend}, 0);
`ifdef CLK_DIV_TICK_CNT_EN
        check("arst_tick_cnt", {16'd0, tick_cnt}, 0);
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
